latch_write_arbiter: RTL and testbench
======================================

Name: latch_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DATA_W-bit level-sensitive latch bank (d/en/q) among NUM_REQ requesters.
- Each granted write is sequenced as three phases: setup with en low, open window with en high, then hold with en low. The requester is then acknowledged.
- Sits between requesting blocks and the latch bank. It guarantees d is stable around every en pulse and that only one requester drives the latch at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, latch data width.
- SETUP_CYC, 1, cycles latch_d is stable before latch_en rises (>=1).
- OPEN_CYC, 2, cycles latch_en is held high (>=1).
- HOLD_CYC, 1, cycles latch_d is held after latch_en falls (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request, level; held until ack.
- wdata  input  NUM_REQ*DATA_W  flattened write data; slice i belongs to req[i].
- ack  output  NUM_REQ  one-cycle one-hot pulse, write of requester i complete.
- grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
- busy  output  1  high in any state other than IDLE.
- latch_d  output  DATA_W  data to latch bank d.
- latch_en  output  1  latch bank enable.

Behaviour:
- Reset: one clock with rst=1 forces the following, regardless of state:
  - state=IDLE; latch_en=0; latch_d=0; ack=0; busy=0; grant_id=0.
  - rr pointer = 0, meaning requester 0 has highest priority.
  - A write interrupted mid-sequence is abandoned and gets no ack. It re-arbitrates after reset if req is still high.
- FSM states: IDLE, SETUP, OPEN, HOLD, ACK. A phase counter is reloaded on every state entry.
- IDLE: if any req is high, pick the first asserted index at or after the rr pointer, wrapping modulo NUM_REQ. Then:
  - register grant_id and capture that slice of wdata into latch_d;
  - go to SETUP.
  - If no req is high, stay in IDLE.
- SETUP: latch_en=0 for SETUP_CYC cycles, then go to OPEN.
- OPEN: latch_en=1 for exactly OPEN_CYC cycles, then go to HOLD.
- HOLD: latch_en=0 for HOLD_CYC cycles, then go to ACK.
- ACK: one cycle with ack[grant_id]=1; rr pointer = grant_id+1, wrapping NUM_REQ-1 to 0. Next state is IDLE.
- latch_d is registered at the grant and does not change until the next grant. wdata changes after the grant are ignored.
- latch_en and ack are registered outputs with no combinational path from req.
- Latency from req seen in IDLE to ack is 1+SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles. The defaults give 6.
- A req deasserted after grant does not abort the sequence; ack is still issued.
- Requests arriving while busy wait. No back-to-back bypass: at least one IDLE cycle separates grants.
- Simultaneous requests are served in round-robin order, one grant per sequence.
- A requester that keeps req high after its ack is re-granted only after every other pending requester has been served.

Optional Feature:
- Macro: LATCH_READBACK_EN.
- Defined:
  - adds input latch_q [DATA_W] and output wr_err [1].
  - In the last HOLD cycle latch_q is compared with latch_d.
  - On mismatch, wr_err pulses for one cycle, coincident with ack.
  - wr_err resets to 0.
- Undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package latch_arb_pkg holds:
  - the state enum (IDLE, SETUP, OPEN, HOLD, ACK);
  - the default timing constants;
  - the function computing the counter width from the max of SETUP_CYC/OPEN_CYC/HOLD_CYC.
- One sub-module, rr_picker: combinational round-robin selector taking req and the pointer and returning valid plus index.
- The FSM, phase counter and data capture stay in latch_write_arbiter.

Test Plan:
- Reset mid-OPEN: with req[1]=1 and wdata[1]=8'hA5, assert rst in OPEN -> next cycle latch_en=0, latch_d=0, busy=0, and no ack[1] pulse.
- Single write: req[2]=1, wdata[2]=8'h3C with defaults -> latch_d=3C one cycle before latch_en. latch_en is high for 2 cycles, latch_d=3C for 1 cycle after it falls, and ack=4'b0100 arrives 6 cycles after req is sampled.
- Round robin: req=4'b1111 held, with ack'd bits deasserted on ack -> grant order 0,1,2,3 and exactly one ack bit per sequence.
- Fairness: req[0] held permanently, req[3] asserted later -> grants alternate 0,3,0,... and req[3] waits at most one sequence.
- Data stability: change wdata[0] from 8'h11 to 8'hFF during OPEN -> latch_d stays 11 and the latch model q=11 after ack.
- LATCH_READBACK_EN: model latch_q stuck at 8'h00 while writing 8'h81 -> wr_err=1 in the same cycle as ack; a correct latch_q gives wr_err=0.

Source files
------------

// File: rtl/latch_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : latch_arb_pkg
//  Description : Shared types and constants for latch_write_arbiter: the
//                sequencer state enum, default timing constants and the
//                phase-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package latch_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_OPEN_CYC  = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // The phase counter counts down from (phase length - 1) to 0, so it only
  // has to represent the longest phase minus one. Never narrower than 1 bit.
  function automatic int cnt_width(input int setup_cyc, input int open_cyc,
                                   input int hold_cyc);
    int mx;
    mx = setup_cyc;
    if (open_cyc > mx) mx = open_cyc;
    if (hold_cyc > mx) mx = hold_cyc;
    return (mx > 1) ? $clog2(mx) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/latch_write_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Returns the first
//                asserted request at or after the pointer, wrapping modulo
//                NUM_REQ.
//  Ports       : req   [NUM_REQ] in  - request vector
//                ptr   [IDX_W]   in  - highest-priority index
//                valid [1]       out - at least one request asserted
//                idx   [IDX_W]   out - selected index (0 when !valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset down to offset 0 so the nearest asserted
  // request (smallest offset from ptr) is the last, and winning, assignment.
  always_comb begin
    int c;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        valid = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : latch_write_arbiter
//  Description : Round-robin arbiter that shares one level-sensitive latch
//                bank among NUM_REQ requesters. Each grant is sequenced as
//                SETUP (en low) -> OPEN (en high) -> HOLD (en low) -> ACK.
//  Ports       : clk, rst (sync, active high)
//                req      [NUM_REQ]        in  - level requests, held to ack
//                wdata    [NUM_REQ*DATA_W] in  - slice i belongs to req[i]
//                ack      [NUM_REQ]        out - one-cycle one-hot completion
//                grant_id [$clog2(NUM_REQ)] out - current/last grant
//                busy     [1]              out - sequencer not idle
//                latch_d  [DATA_W]         out - latch bank data
//                latch_en [1]              out - latch bank enable
//  Option      : LATCH_READBACK_EN adds latch_q [DATA_W] in and wr_err [1]
//                out; wr_err pulses with ack when the latch did not take
//                the written value.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int OPEN_CYC  = DEF_OPEN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [DATA_W-1:0]          latch_d,
  output logic                       latch_en
`ifdef LATCH_READBACK_EN
  ,
  input  logic [DATA_W-1:0]          latch_q,
  output logic                       wr_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  localparam logic [CW-1:0]    SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]    OPEN_LD  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0]    HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]   ptr, ptr_inc;
  logic [NUM_REQ-1:0] ack_nxt;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy    = (state != IDLE);
  assign ptr_inc = (grant_id == LAST_IDX) ? '0 : grant_id + IDX_W'(1);

  // Next state, phase counter and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = '0;

    case (state)
      IDLE:  if (pick_valid) state_nxt = SETUP;
      SETUP: if (cnt == '0)  state_nxt = OPEN;
      OPEN:  if (cnt == '0)  state_nxt = HOLD;
      HOLD:  if (cnt == '0)  state_nxt = ACK;
      ACK:                   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase

    // Reload on every state entry; otherwise count down toward zero.
    if (state_nxt != state) begin
      case (state_nxt)
        SETUP:   cnt_nxt = SETUP_LD;
        OPEN:    cnt_nxt = OPEN_LD;
        HOLD:    cnt_nxt = HOLD_LD;
        default: cnt_nxt = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CW'(1);
    end

    if (state_nxt == ACK) ack_nxt[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant_id <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      ack      <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      latch_en <= (state_nxt == OPEN);
      ack      <= ack_nxt;
      // Data is captured only at the grant, so later wdata edits cannot
      // disturb d around the enable pulse.
      if (state == IDLE && pick_valid) begin
        grant_id <= pick_idx;
        latch_d  <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
      end
      if (state == ACK) ptr <= ptr_inc;
    end
  end

`ifdef LATCH_READBACK_EN
  // Compare in the last HOLD cycle; the registered flag lands in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= (state == HOLD) && (cnt == '0) && (latch_q != latch_d);
    end
  end
`else
  // No readback path: the latch contents are trusted.
`endif

endmodule
`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latch_write_arbiter
//  Description : Directed self-checking bench for latch_write_arbiter with
//                default parameters (4 requesters, 8-bit data, 1/2/1 timing).
//  Option      : LATCH_READBACK_EN enables the readback steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  latch_d;
  logic        latch_en;
  logic [7:0]  lq;        // behavioural latch bank
  int          errors = 0;
  int          checks = 0;

`ifdef LATCH_READBACK_EN
  logic        stuck;
  logic [7:0]  latch_q;
  logic        wr_err;
  assign latch_q = stuck ? 8'h00 : lq;
`endif

  always #5 clk = ~clk;

  always_latch begin
    if (latch_en) lq <= latch_d;
  end

  latch_write_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .latch_d  (latch_d),
    .latch_en (latch_en)
`ifdef LATCH_READBACK_EN
    ,
    .latch_q  (latch_q),
    .wr_err   (wr_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until ack is seen (bounded); leaves time just after that edge.
  task automatic wait_ack(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ack != 4'b0000) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic       ack_seen;
    logic [3:0] exp_ack;
    int         order[4];

    // ---------------- reset state ----------------
    rst = 1'b1; req = 4'b0000; wdata = '0;
`ifdef LATCH_READBACK_EN
    stuck = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_en",    {31'd0, latch_en}, 32'd0);
    chk("rst_d",     {24'd0, latch_d},  32'd0);
    chk("rst_ack",   {28'd0, ack},      32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_gid",   {30'd0, grant_id}, 32'd0);

    // ---------------- reset mid-OPEN ----------------
    req = 4'b0010; wdata[15:8] = 8'hA5;
    tick();                                   // grant -> SETUP
    tick();                                   // OPEN
    chk("mid_open_en", {31'd0, latch_en}, 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_en",   {31'd0, latch_en}, 32'd0);
    chk("abort_d",    {24'd0, latch_d},  32'd0);
    chk("abort_busy", {31'd0, busy},     32'd0);
    rst = 1'b0; req = 4'b0000;
    ack_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ack != 4'b0000) ack_seen = 1'b1;
      tick();
    end
    chk("abort_no_ack", {31'd0, ack_seen}, 32'd0);

    // ---------------- single write ----------------
    wdata = '0; wdata[23:16] = 8'h3C; req = 4'b0100;
    tick();                                   // SETUP
    chk("sw_setup_d",  {24'd0, latch_d},  32'h3C);
    chk("sw_setup_en", {31'd0, latch_en}, 32'd0);
    chk("sw_busy",     {31'd0, busy},     32'd1);
    chk("sw_gid",      {30'd0, grant_id}, 32'd2);
    tick();
    chk("sw_open1_en", {31'd0, latch_en}, 32'd1);
    tick();
    chk("sw_open2_en", {31'd0, latch_en}, 32'd1);
    chk("sw_open_ack", {28'd0, ack},      32'd0);
    tick();                                   // HOLD
    chk("sw_hold_en",  {31'd0, latch_en}, 32'd0);
    chk("sw_hold_d",   {24'd0, latch_d},  32'h3C);
    chk("sw_hold_ack", {28'd0, ack},      32'd0);
    tick();                                   // ACK
    chk("sw_ack",      {28'd0, ack},      32'h4);
    chk("sw_latch_q",  {24'd0, lq},       32'h3C);
    req = 4'b0000;
    tick();
    chk("sw_ack_pulse", {28'd0, ack},  32'd0);
    chk("sw_idle_busy", {31'd0, busy}, 32'd0);

    // ---------------- round robin from pointer 0 ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    wdata = 32'h44332211;
    req = 4'b1111;
    order = '{0, 1, 2, 3};
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr_wait");
      exp_ack = 4'b0001 << order[k];
      chk("rr_ack", {28'd0, ack},      {28'd0, exp_ack});
      chk("rr_gid", {30'd0, grant_id}, order[k]);
      chk("rr_q",   {24'd0, lq},       {24'd0, wdata[order[k]*8 +: 8]});
      req = req & ~exp_ack;
    end
    tick();

    // ---------------- fairness: req[0] held, req[3] joins ----------------
    req = 4'b0001;
    wait_ack("fair_wait0");
    chk("fair_ack0", {28'd0, ack}, 32'h1);
    req = 4'b1001;
    order = '{3, 0, 3, 0};
    for (int k = 0; k < 4; k++) begin
      wait_ack("fair_wait");
      exp_ack = 4'b0001 << order[k];
      chk("fair_ack", {28'd0, ack}, {28'd0, exp_ack});
    end
    req = 4'b0000;
    tick(); tick();

    // ---------------- data stability ----------------
    wdata = '0; wdata[7:0] = 8'h11; req = 4'b0001;
    tick();
    chk("ds_setup_d", {24'd0, latch_d}, 32'h11);
    tick();
    wdata[7:0] = 8'hFF;
    tick();
    chk("ds_open_d", {24'd0, latch_d}, 32'h11);
    wait_ack("ds_wait");
    chk("ds_ack",   {28'd0, ack},     32'h1);
    chk("ds_ack_d", {24'd0, latch_d}, 32'h11);
    chk("ds_q",     {24'd0, lq},      32'h11);
    req = 4'b0000;
    tick();

`ifdef LATCH_READBACK_EN
    // ---------------- readback ----------------
    chk("rb_idle_err", {31'd0, wr_err}, 32'd0);
    stuck = 1'b1; wdata = '0; wdata[15:8] = 8'h81; req = 4'b0010;
    wait_ack("rb_bad_wait");
    chk("rb_bad_ack", {28'd0, ack},    32'h2);
    chk("rb_bad_err", {31'd0, wr_err}, 32'd1);
    req = 4'b0000;
    tick();
    chk("rb_err_pulse", {31'd0, wr_err}, 32'd0);
    stuck = 1'b0; wdata[23:16] = 8'h81; req = 4'b0100;
    wait_ack("rb_ok_wait");
    chk("rb_ok_ack", {28'd0, ack},    32'h4);
    chk("rb_ok_err", {31'd0, wr_err}, 32'd0);
    req = 4'b0000;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
